obstacle_engine: RTL and testbench

OBSTACLE_ENGINE -- requirements
Module: obstacle_engine

---
 rtl/obstacle_engine.sv | 201 ++++++++++++++++++++
 tb/tb_obstacle_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_engine.sv
// Falling-obstacle engine: slot movement, spawning, scoring, collision and game FSM.
// Outputs are registered slot state; oState/oCrash decode the state register.
module obstacle_engine #(
  parameter int N_OBS      = 3,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int SCREEN_H   = 480,
  parameter int OBS_W      = 60,
  parameter int OBS_H      = 60,
  parameter int STEP       = 8,
  parameter int PLAYER_Y   = 400,
  parameter int PLAYER_W   = 40,
  parameter int PLAYER_H   = 40,
  parameter int LANE_BITS  = 2,
  parameter int LANE_X0    = 160,
  parameter int LANE_PITCH = 80,
  parameter int SPAWN_GAP  = 20,
  parameter int SCORE_W    = 9
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iTick,
  input  logic                   iStart,
  input  logic [X_W-1:0]         iPlayerX,
  output logic [N_OBS*X_W-1:0]   oObsX,
  output logic [N_OBS*Y_W-1:0]   oObsY,
  output logic [N_OBS-1:0]       oObsValid,
  output logic [SCORE_W-1:0]     oScore,
  output logic [1:0]             oState,
  output logic                   oCrash
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CRASH = 2'b10
  } state_t;

  localparam int CNT_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SPAWN_GAP - 1);
  localparam logic [Y_W:0]     Y_STEP   = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]     Y_LIMIT  = (Y_W+1)'(SCREEN_H);
  localparam logic [SCORE_W:0] EXIT_ONE = (SCORE_W+1)'(1);

  state_t             state_q, state_d;
  logic [X_W-1:0]     obs_x_q [N_OBS];
  logic [X_W-1:0]     obs_x_d [N_OBS];
  logic [Y_W-1:0]     obs_y_q [N_OBS];
  logic [Y_W-1:0]     obs_y_d [N_OBS];
  logic [N_OBS-1:0]   valid_q, valid_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8:0]         lfsr_q, lfsr_d;

  logic               collision;
  logic [N_OBS-1:0]   spawn_sel;
  logic [X_W-1:0]     lane_x;
  logic [Y_W:0]       y_next [N_OBS];
  logic [SCORE_W:0]   n_exit;
  logic [SCORE_W:0]   score_sum;

  // Lowest clear bit of the pre-tick valid vector; zero when every slot is busy.
  assign spawn_sel = ~valid_q & (valid_q + N_OBS'(1));
  assign lane_x    = X_W'(LANE_X0 + LANE_PITCH * int'(lfsr_q[LANE_BITS-1:0]));

  always_comb begin
    collision = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (valid_q[i]
          && (32'(obs_x_q[i]) < 32'(iPlayerX) + 32'(PLAYER_W))
          && (32'(iPlayerX) < 32'(obs_x_q[i]) + 32'(OBS_W))
          && (32'(obs_y_q[i]) + 32'(OBS_H) > 32'(PLAYER_Y))
          && (32'(obs_y_q[i]) < 32'(PLAYER_Y) + 32'(PLAYER_H)))
        collision = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_OBS; i++) y_next[i] = {1'b0, obs_y_q[i]} + Y_STEP;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d = state_q;
    obs_x_d = obs_x_q;
    obs_y_d = obs_y_q;
    valid_d = valid_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
    n_exit  = '0;
    score_sum = {1'b0, score_q};

    unique case (state_q)
      ST_IDLE: begin
        for (int i = 0; i < N_OBS; i++) begin
          obs_x_d[i] = '0;
          obs_y_d[i] = '0;
        end
        valid_d = '0;
        score_d = '0;
        cnt_d   = CNT_MAX;
        if (iStart) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (collision) begin
          state_d = ST_CRASH;
        end else if (iTick) begin
          for (int i = 0; i < N_OBS; i++) begin
            if (valid_q[i]) begin
              if (y_next[i] >= Y_LIMIT) begin
                valid_d[i] = 1'b0;
                n_exit     = n_exit + EXIT_ONE;
              end else begin
                obs_y_d[i] = y_next[i][Y_W-1:0];
              end
            end
          end
          score_sum = {1'b0, score_q} + n_exit;
          score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

          // A dropped spawn leaves the counter at its terminal value to retry next tick.
          if (cnt_q == CNT_MAX) begin
            if (|spawn_sel) begin
              cnt_d = '0;
              for (int i = 0; i < N_OBS; i++) begin
                if (spawn_sel[i]) begin
                  obs_x_d[i] = lane_x;
                  obs_y_d[i] = '0;
                  valid_d[i] = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_CRASH: begin
        if (iStart) begin
          state_d = ST_IDLE;
          for (int i = 0; i < N_OBS; i++) begin
            obs_x_d[i] = '0;
            obs_y_d[i] = '0;
          end
          valid_d = '0;
          score_d = '0;
          cnt_d   = CNT_MAX;
        end
      end

      default: begin
        state_d = ST_IDLE;
        for (int i = 0; i < N_OBS; i++) begin
          obs_x_d[i] = '0;
          obs_y_d[i] = '0;
        end
        valid_d = '0;
        score_d = '0;
        cnt_d   = CNT_MAX;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      // NOTE: the slot arrays are tiny and their reset contents are visible, so they are reset.
      for (int i = 0; i < N_OBS; i++) begin
        obs_x_q[i] <= '0;
        obs_y_q[i] <= '0;
      end
      valid_q <= '0;
      score_q <= '0;
      cnt_q   <= CNT_MAX;
      lfsr_q  <= 9'h1FF;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      obs_x_q <= obs_x_d;
      obs_y_q <= obs_y_d;
      valid_q <= valid_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  for (genvar g = 0; g < N_OBS; g++) begin : g_pack
    assign oObsX[g*X_W +: X_W] = obs_x_q[g];
    assign oObsY[g*Y_W +: Y_W] = obs_y_q[g];
  end

  assign oObsValid = valid_q;
  assign oScore    = score_q;
  assign oState    = state_q;
  assign oCrash    = (state_q == ST_CRASH);

endmodule

// File: tb/tb_obstacle_engine.sv
// Randomised bench for obstacle_engine: a game-level reference model predicts every
// output after each clock edge, with hand-computed literal checks at key points.
module tb_obstacle_engine;

  localparam int N = 3;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int GAP = 20;
  localparam int SAT = 511;

  logic              iClk = 1'b0;
  logic              iReset = 1'b1;
  logic              iTick = 1'b0;
  logic              iStart = 1'b0;
  logic [XW-1:0]     iPlayerX = '0;
  logic [N*XW-1:0]   oObsX;
  logic [N*YW-1:0]   oObsY;
  logic [N-1:0]      oObsValid;
  logic [8:0]        oScore;
  logic [1:0]        oState;
  logic              oCrash;

  obstacle_engine dut (
    .iClk(iClk), .iReset(iReset), .iTick(iTick), .iStart(iStart), .iPlayerX(iPlayerX),
    .oObsX(oObsX), .oObsY(oObsY), .oObsValid(oObsValid), .oScore(oScore),
    .oState(oState), .oCrash(oCrash)
  );

  always #5 iClk = ~iClk;

  // Game-level model: 0=idle, 1=run, 2=crash.
  int m_state, m_score, m_cnt, m_lfsr;
  int m_x [N];
  int m_y [N];
  bit m_v [N];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dut_x(int i);
    return int'(oObsX[i*XW +: XW]);
  endfunction

  function automatic int dut_y(int i);
    return int'(oObsY[i*YW +: YW]);
  endfunction

  function automatic bit model_coll(int px);
    bit hit = 0;
    for (int i = 0; i < N; i++)
      if (m_v[i] && m_x[i] < px + 40 && px < m_x[i] + 60 && m_y[i] + 60 > 400 && m_y[i] < 440)
        hit = 1;
    return hit;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_v[i] = 0;
    end
    m_score = 0;
    m_cnt = GAP - 1;
  endtask

  task automatic model_reset();
    model_clear();
    m_state = 0;
    m_lfsr = 'h1FF;
  endtask

  task automatic model_edge(bit tick, bit start, int px);
    bit coll = model_coll(px);
    int lane = m_lfsr % 4;
    bit was_free [N];
    int slot = -1;
    for (int i = 0; i < N; i++) was_free[i] = !m_v[i];
    m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 8) ^ (m_lfsr >> 4)) & 1)) & 'h1FF;
    case (m_state)
      0: if (start) m_state = 1;
      1: begin
        if (coll) m_state = 2;
        else if (tick) begin
          for (int i = 0; i < N; i++)
            if (m_v[i]) begin
              m_y[i] += 8;
              if (m_y[i] >= 480) begin
                m_v[i] = 0;
                if (m_score < SAT) m_score++;
              end
            end
          if (m_cnt == GAP - 1) begin
            for (int i = 0; i < N; i++) if (was_free[i] && slot < 0) slot = i;
            if (slot >= 0) begin
              m_x[slot] = 160 + 80 * lane;
              m_y[slot] = 0;
              m_v[slot] = 1;
              m_cnt = 0;
            end
          end else m_cnt++;
        end
      end
      default: if (start) begin model_clear(); m_state = 0; end
    endcase
  endtask

  task automatic compare_all();
    check("state", int'(oState), m_state);
    check("crash", int'(oCrash), (m_state == 2) ? 1 : 0);
    check("score", int'(oScore), m_score);
    for (int i = 0; i < N; i++) begin
      check($sformatf("valid%0d", i), int'(oObsValid[i]), int'(m_v[i]));
      if (m_v[i]) begin
        check($sformatf("x%0d", i), dut_x(i), m_x[i]);
        check($sformatf("y%0d", i), dut_y(i), m_y[i]);
      end
    end
  endtask

  task automatic cycle(bit tick, bit start, int px);
    iTick = tick;
    iStart = start;
    iPlayerX = px[XW-1:0];
    model_edge(tick, start, px);
    @(posedge iClk);
    #1;
    compare_all();
  endtask

  initial begin
    int guard;
    int k;
    int px;
    int pre_y;
    bit hit;

    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    compare_all();
    for (int i = 0; i < N; i++) begin
      check("rst_x", dut_x(i), 0);
      check("rst_y", dut_y(i), 0);
    end
    check("rst_valid", int'(oObsValid), 0);
    iReset = 1'b0;

    // First spawn: LFSR advanced once to 0x1FE, lane 2 -> X=320.
    cycle(0, 1, 0);
    check("start_run", int'(oState), 1);
    cycle(1, 0, 0);
    check("spawn_valid", int'(oObsValid), 1);
    check("spawn_y", dut_y(0), 0);
    check("spawn_x", dut_x(0), 320);
    repeat (59) cycle(1, 0, 0);
    check("y_472", dut_y(0), 472);
    cycle(1, 0, 0);
    check("exit_valid", int'(oObsValid), 6);
    check("exit_score", int'(oScore), 1);
    cycle(1, 0, 0);
    check("retry_fill", int'(oObsValid), 7);

    repeat (600) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

    guard = 0;
    while (m_score < SAT && guard < 12000) begin
      cycle(1, 1'($urandom_range(0, 1)), 0);
      guard++;
    end
    check("sat_reach", int'(oScore), SAT);
    repeat (100) cycle(1, 0, 0);
    check("sat_hold", int'(oScore), SAT);

    // Chase the lowest obstacle until it overlaps while iTick is high.
    guard = 0; hit = 0; k = 0; pre_y = -1; px = 0;
    while (!hit && guard < 400) begin
      k = -1;
      for (int i = 0; i < N; i++) if (m_v[i] && (k < 0 || m_y[i] > m_y[k])) k = i;
      px = (k >= 0) ? m_x[k] : 0;
      if (k >= 0 && model_coll(px)) begin
        hit = 1;
        pre_y = m_y[k];
      end
      cycle(1, 0, px);
      guard++;
    end
    if (k < 0) k = 0;
    check("coll_state", int'(oState), 2);
    check("coll_y_frozen", dut_y(k), pre_y);
    check("coll_score", int'(oScore), SAT);
    repeat (5) cycle(1'($urandom_range(0, 1)), 0, px);
    check("crash_y_hold", dut_y(k), pre_y);

    cycle(1'($urandom_range(0, 1)), 1, 0);
    check("crash_to_idle", int'(oState), 0);
    repeat (10) cycle(1'($urandom_range(0, 1)), 0, 0);
    check("idle_score", int'(oScore), 0);

    cycle(0, 1, 0);
    cycle(1, 0, 0);
    px = m_x[0];
    repeat (43) cycle(1, 0, px);
    check("y_344", dut_y(0), 344);
    check("pre_crash_run", int'(oState), 1);
    cycle(1, 0, px);
    check("crash_state", int'(oState), 2);
    check("crash_flag", int'(oCrash), 1);
    check("crash_y", dut_y(0), 344);
    repeat (3) cycle(1, 0, px);
    check("crash_y_stay", dut_y(0), 344);

    cycle(0, 1, 0);
    cycle(0, 1, 0);
    repeat (25) cycle(1, 0, 0);
    check("two_valid", int'(oObsValid), 3);
    #2;
    iReset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("arst_valid", int'(oObsValid), 0);
    check("arst_score", int'(oScore), 0);
    check("arst_state", int'(oState), 0);
    @(posedge iClk);
    #1;
    iReset = 1'b0;
    repeat (3) cycle(1, 0, 0);
    check("stay_idle", int'(oState), 0);

    repeat (1500) begin
      px = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 600)) : 0;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), px);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
